// File: rtl/dmem_resp_pkg.sv
// Shared constants for the data-memory responder: load/store func3 codes
// and the read-FSM state encoding.
package dmem_resp_pkg;

  // Load func3 codes
  localparam logic [2:0] INST_LB  = 3'b000;
  localparam logic [2:0] INST_LH  = 3'b001;
  localparam logic [2:0] INST_LW  = 3'b010;
  localparam logic [2:0] INST_LBU = 3'b100;
  localparam logic [2:0] INST_LHU = 3'b101;

  // Store func3 codes
  localparam logic [2:0] INST_SB  = 3'b000;
  localparam logic [2:0] INST_SH  = 3'b001;
  localparam logic [2:0] INST_SW  = 3'b010;

  // Read FSM states
  typedef enum logic [1:0] {
    DMEM_IDLE = 2'd0,
    DMEM_WAIT = 2'd1,
    DMEM_RESP = 2'd2
  } dmem_state_e;

endpackage

// File: rtl/dmem_resp_if.sv
// Bus bundle between a requester (master) and the data-memory responder
// (slave): load request/response, store request and the error pulse.
interface dmem_resp_if;

  logic        mem_rd_req_i;
  logic [31:0] mem_rd_addr_i;
  logic [2:0]  mem_rd_func3_i;
  logic [31:0] mem_rd_data_o;
  logic        mem_rd_valid_o;
  logic        mem_busy_o;
  logic        mem_wr_req_i;
  logic [31:0] mem_wr_addr_i;
  logic [31:0] mem_wr_data_i;
  logic [2:0]  mem_wr_func3_i;
  logic        mem_err_o;

  modport slave (
    input  mem_rd_req_i, mem_rd_addr_i, mem_rd_func3_i,
    input  mem_wr_req_i, mem_wr_addr_i, mem_wr_data_i, mem_wr_func3_i,
    output mem_rd_data_o, mem_rd_valid_o, mem_busy_o, mem_err_o
  );

  modport master (
    output mem_rd_req_i, mem_rd_addr_i, mem_rd_func3_i,
    output mem_wr_req_i, mem_wr_addr_i, mem_wr_data_i, mem_wr_func3_i,
    input  mem_rd_data_o, mem_rd_valid_o, mem_busy_o, mem_err_o
  );

endinterface

// File: rtl/dmem_resp_lane_align.sv
// Combinational lane logic for the data memory: store byte enables and
// lane replication, load lane select with sign/zero extension, and the
// alignment/illegal-func3 checks for both directions.
module dmem_lane_align
  import dmem_resp_pkg::*;
(
  input  logic [1:0]  wr_off_i,
  input  logic [2:0]  wr_func3_i,
  input  logic [31:0] wr_data_i,
  output logic [3:0]  wr_be_o,
  output logic [31:0] wr_lanes_o,
  output logic        wr_err_o,

  input  logic [1:0]  rd_off_i,
  input  logic [2:0]  rd_func3_i,
  output logic        rd_err_o,

  input  logic [31:0] ld_word_i,
  input  logic [1:0]  ld_off_i,
  input  logic [2:0]  ld_func3_i,
  output logic [31:0] ld_data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Store: enables and replicated lanes; a bad store gets no enables at all
  always_comb begin
    wr_be_o    = 4'b0000;
    wr_lanes_o = 32'h0;
    wr_err_o   = 1'b1;
    case (wr_func3_i)
      INST_SB: begin
        wr_be_o    = 4'b0001 << wr_off_i;
        wr_lanes_o = {4{wr_data_i[7:0]}};
        wr_err_o   = 1'b0;
      end
      INST_SH: begin
        wr_be_o    = wr_off_i[1] ? 4'b1100 : 4'b0011;
        wr_lanes_o = {2{wr_data_i[15:0]}};
        wr_err_o   = wr_off_i[0];
      end
      INST_SW: begin
        wr_be_o    = 4'b1111;
        wr_lanes_o = wr_data_i;
        wr_err_o   = |wr_off_i;
      end
      default: ;
    endcase
    if (wr_err_o) begin
      wr_be_o = 4'b0000;
    end
  end

  // Load request check: misaligned halves/words and unused func3 codes
  always_comb begin
    rd_err_o = 1'b1;
    case (rd_func3_i)
      INST_LB, INST_LBU: rd_err_o = 1'b0;
      INST_LH, INST_LHU: rd_err_o = rd_off_i[0];
      INST_LW:           rd_err_o = |rd_off_i;
      default:           rd_err_o = 1'b1;
    endcase
  end

  // Load data: pick the addressed lane, then extend to 32 bits
  always_comb begin
    byte_sel  = 8'h00;
    half_sel  = ld_off_i[1] ? ld_word_i[31:16] : ld_word_i[15:0];
    ld_data_o = 32'h0;
    case (ld_off_i)
      2'd0: byte_sel = ld_word_i[7:0];
      2'd1: byte_sel = ld_word_i[15:8];
      2'd2: byte_sel = ld_word_i[23:16];
      2'd3: byte_sel = ld_word_i[31:24];
      default: byte_sel = 8'h00;
    endcase
    case (ld_func3_i)
      INST_LB:  ld_data_o = {{24{byte_sel[7]}}, byte_sel};
      INST_LBU: ld_data_o = {24'h0, byte_sel};
      INST_LH:  ld_data_o = {{16{half_sel[15]}}, half_sel};
      INST_LHU: ld_data_o = {16'h0, half_sel};
      INST_LW:  ld_data_o = ld_word_i;
      default:  ld_data_o = 32'h0;
    endcase
  end

endmodule

// File: rtl/dmem_resp.sv
// Data-memory responder: word RAM with byte-enable stores and a small read
// FSM that returns extended load data after RD_LATENCY cycles.
module dmem_resp
  import dmem_resp_pkg::*;
#(
  parameter int ADDR_W     = 12,
  parameter int RD_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  dmem_resp_if.slave  bus
);

  localparam int         DEPTH    = 1 << ADDR_W;
  localparam logic [1:0] CNT_INIT = (RD_LATENCY > 1) ? 2'(RD_LATENCY - 2) : 2'd0;

  logic [31:0] mem_q [DEPTH];

  dmem_state_e state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] hold_word_q;
  logic [1:0]  hold_off_q;
  logic [2:0]  hold_func3_q;
  logic        hold_err_q;
  logic [31:0] last_data_q;
  logic        wr_err_q;

  logic [ADDR_W-1:0] rd_idx;
  logic [ADDR_W-1:0] wr_idx;
  logic              accept;
  logic              rd_err;
  logic              wr_err;
  logic [3:0]        wr_be;
  logic [31:0]       wr_lanes;
  logic [31:0]       ld_data;
  logic [31:0]       resp_data;
  logic              resp_now;

  // Address bits above the word index are ignored on purpose (aliasing)
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.mem_rd_addr_i[31:ADDR_W+2], bus.mem_wr_addr_i[31:ADDR_W+2]};

  assign rd_idx = bus.mem_rd_addr_i[ADDR_W+1:2];
  assign wr_idx = bus.mem_wr_addr_i[ADDR_W+1:2];
  assign accept = bus.mem_rd_req_i && (state_q != DMEM_WAIT);

  dmem_lane_align u_lane (
    .wr_off_i   (bus.mem_wr_addr_i[1:0]),
    .wr_func3_i (bus.mem_wr_func3_i),
    .wr_data_i  (bus.mem_wr_data_i),
    .wr_be_o    (wr_be),
    .wr_lanes_o (wr_lanes),
    .wr_err_o   (wr_err),
    .rd_off_i   (bus.mem_rd_addr_i[1:0]),
    .rd_func3_i (bus.mem_rd_func3_i),
    .rd_err_o   (rd_err),
    .ld_word_i  (hold_word_q),
    .ld_off_i   (hold_off_q),
    .ld_func3_i (hold_func3_q),
    .ld_data_o  (ld_data)
  );

  // Read FSM next state: count down in WAIT, accept new reads in IDLE/RESP
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      DMEM_IDLE: state_d = DMEM_IDLE;
      DMEM_WAIT: begin
        if (cnt_q == 2'd0) begin
          state_d = DMEM_RESP;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      DMEM_RESP: state_d = DMEM_IDLE;
      default:   state_d = DMEM_IDLE;
    endcase
    if (accept) begin
      if (RD_LATENCY == 1) begin
        state_d = DMEM_RESP;
      end else begin
        state_d = DMEM_WAIT;
        cnt_d   = CNT_INIT;
      end
    end
  end

  // A faulted load returns zero instead of any lane data
  assign resp_now  = (state_q == DMEM_RESP);
  assign resp_data = hold_err_q ? 32'h0 : ld_data;

  assign bus.mem_rd_valid_o = resp_now;
  assign bus.mem_busy_o     = (state_q == DMEM_WAIT);
  assign bus.mem_rd_data_o  = resp_now ? resp_data : last_data_q;
  assign bus.mem_err_o      = (resp_now && hold_err_q) || wr_err_q;

  // FSM state, the read hold register and the delayed store-error flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= DMEM_IDLE;
      cnt_q        <= 2'd0;
      hold_word_q  <= 32'h0;
      hold_off_q   <= 2'd0;
      hold_func3_q <= 3'd0;
      hold_err_q   <= 1'b0;
      last_data_q  <= 32'h0;
      wr_err_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wr_err_q <= bus.mem_wr_req_i && wr_err;
      if (resp_now) begin
        last_data_q <= resp_data;
      end
      if (accept) begin
        hold_word_q  <= mem_q[rd_idx];
        hold_off_q   <= bus.mem_rd_addr_i[1:0];
        hold_func3_q <= bus.mem_rd_func3_i;
        hold_err_q   <= rd_err;
      end
    end
  end

  // RAM byte writes; the read capture above sees the pre-write word
  always_ff @(posedge clk) begin
    if (bus.mem_wr_req_i && !wr_err) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) begin
          mem_q[wr_idx][8*b +: 8] <= wr_lanes[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_resp.sv
// Bench for dmem_resp: a vector table and a randomized run against a
// latency-1 instance, hand-timed sequences against a latency-3 instance.
module tb_dmem_resp;

  logic clk = 1'b0;
  logic rst1;
  logic rst3;
  int   testCount = 0;
  int   failCount = 0;

  typedef struct {
    logic        rd;
    logic [31:0] ra;
    logic [2:0]  rf;
    logic        wr;
    logic [31:0] wa;
    logic [31:0] wd;
    logic [2:0]  wf;
    logic        ev;
    logic [31:0] ed;
    logic        ee;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] modelMem [16];

  dmem_resp_if bus1();
  dmem_resp_if bus3();

  dmem_resp #(.ADDR_W(12), .RD_LATENCY(1)) u_dut1 (.clk(clk), .rst(rst1), .bus(bus1));
  dmem_resp #(.ADDR_W(12), .RD_LATENCY(3)) u_dut3 (.clk(clk), .rst(rst3), .bus(bus3));

  always #5 clk = ~clk;

  function automatic vec_t mkVec(logic rd, logic [31:0] ra, logic [2:0] rf,
                                 logic wr, logic [31:0] wa, logic [31:0] wd, logic [2:0] wf,
                                 logic ev, logic [31:0] ed, logic ee);
    vec_t v;
    v.rd = rd; v.ra = ra; v.rf = rf;
    v.wr = wr; v.wa = wa; v.wd = wd; v.wf = wf;
    v.ev = ev; v.ed = ed; v.ee = ee;
    return v;
  endfunction

  function automatic vec_t idleVec();
    return mkVec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  function automatic logic badLoad(logic [2:0] f, logic [1:0] off);
    if (f == 3'd0 || f == 3'd4) return 1'b0;
    if (f == 3'd1 || f == 3'd5) return (off % 2) != 0;
    if (f == 3'd2) return off != 0;
    return 1'b1;
  endfunction

  function automatic logic badStore(logic [2:0] f, logic [1:0] off);
    if (f == 3'd0) return 1'b0;
    if (f == 3'd1) return (off % 2) != 0;
    if (f == 3'd2) return off != 0;
    return 1'b1;
  endfunction

  function automatic logic [31:0] modelLoad(logic [31:0] word, logic [1:0] off, logic [2:0] f);
    logic [31:0] sh;
    logic [31:0] v;
    sh = word >> (8 * off);
    case (f)
      3'd0: begin v = sh & 32'hFF;   if (v >= 32'd128)   v = v + 32'hFFFFFF00; end
      3'd4: v = sh & 32'hFF;
      3'd1: begin v = sh & 32'hFFFF; if (v >= 32'd32768) v = v + 32'hFFFF0000; end
      3'd5: v = sh & 32'hFFFF;
      3'd2: v = word;
      default: v = 32'h0;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] modelStore(logic [31:0] old, logic [31:0] data,
                                             logic [1:0] off, logic [2:0] f);
    logic [31:0] mask;
    if (f == 3'd0)      mask = 32'hFF;
    else if (f == 3'd1) mask = 32'hFFFF;
    else                mask = 32'hFFFFFFFF;
    mask = mask << (8 * off);
    return (old & ~mask) | ((data << (8 * off)) & mask);
  endfunction

  task automatic applyStimulus(input int which, input vec_t v);
    if (which == 1) begin
      bus1.mem_rd_req_i   = v.rd; bus1.mem_rd_addr_i = v.ra; bus1.mem_rd_func3_i = v.rf;
      bus1.mem_wr_req_i   = v.wr; bus1.mem_wr_addr_i = v.wa;
      bus1.mem_wr_data_i  = v.wd; bus1.mem_wr_func3_i = v.wf;
    end else begin
      bus3.mem_rd_req_i   = v.rd; bus3.mem_rd_addr_i = v.ra; bus3.mem_rd_func3_i = v.rf;
      bus3.mem_wr_req_i   = v.wr; bus3.mem_wr_addr_i = v.wa;
      bus3.mem_wr_data_i  = v.wd; bus3.mem_wr_func3_i = v.wf;
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check3(input string tag, input logic v, input logic b,
                        input logic [31:0] d, input logic e);
    checkOutput({tag, " valid"}, 32'(bus3.mem_rd_valid_o), 32'(v));
    checkOutput({tag, " busy"},  32'(bus3.mem_busy_o),     32'(b));
    checkOutput({tag, " data"},  bus3.mem_rd_data_o,       d);
    checkOutput({tag, " err"},   32'(bus3.mem_err_o),      32'(e));
  endtask

  initial begin
    logic [31:0] expLast;
    vec_t        v;

    rst1 = 1'b1;
    rst3 = 1'b1;
    applyStimulus(1, idleVec());
    applyStimulus(3, idleVec());
    tick();
    tick();

    // Reset state of both instances
    checkOutput("rst1 data",  bus1.mem_rd_data_o, 32'h0);
    checkOutput("rst1 valid", 32'(bus1.mem_rd_valid_o), 32'h0);
    checkOutput("rst1 busy",  32'(bus1.mem_busy_o), 32'h0);
    checkOutput("rst1 err",   32'(bus1.mem_err_o), 32'h0);
    check3("rst3", 0, 0, 32'h0, 0);
    rst1 = 1'b0;
    rst3 = 1'b0;
    tick();

    // Vector table for the latency-1 instance; outputs checked one cycle later
    vecs.push_back(mkVec(0, 32'h0, 3'd0, 1, 32'h10, 32'hDEADBEEF, 3'd2, 0, 32'h0,        0));
    vecs.push_back(mkVec(1, 32'h10, 3'd2, 0, 0, 0, 0,                   1, 32'hDEADBEEF, 0));
    vecs.push_back(mkVec(1, 32'h13, 3'd0, 0, 0, 0, 0,                   1, 32'hFFFFFFDE, 0));
    vecs.push_back(mkVec(1, 32'h13, 3'd4, 0, 0, 0, 0,                   1, 32'h000000DE, 0));
    vecs.push_back(mkVec(1, 32'h12, 3'd1, 0, 0, 0, 0,                   1, 32'hFFFFDEAD, 0));
    vecs.push_back(mkVec(1, 32'h10, 3'd5, 0, 0, 0, 0,                   1, 32'h0000BEEF, 0));
    vecs.push_back(mkVec(0, 32'h0, 3'd0, 1, 32'h11, 32'h000000AA, 3'd0, 0, 32'h0000BEEF, 0));
    vecs.push_back(mkVec(1, 32'h10, 3'd2, 0, 0, 0, 0,                   1, 32'hDEADAAEF, 0));
    vecs.push_back(mkVec(1, 32'h10, 3'd2, 1, 32'h10, 32'h0, 3'd2,       1, 32'hDEADAAEF, 0));
    vecs.push_back(mkVec(1, 32'h10, 3'd2, 0, 0, 0, 0,                   1, 32'h0,        0));
    vecs.push_back(mkVec(0, 32'h0, 3'd0, 1, 32'h10, 32'h12345678, 3'd2, 0, 32'h0,        0));
    vecs.push_back(mkVec(1, 32'h12, 3'd2, 0, 0, 0, 0,                   1, 32'h0,        1));
    vecs.push_back(mkVec(0, 32'h0, 3'd0, 1, 32'h11, 32'h00005555, 3'd1, 0, 32'h0,        1));
    vecs.push_back(mkVec(1, 32'h4010, 3'd2, 0, 0, 0, 0,                 1, 32'h12345678, 0));
    vecs.push_back(mkVec(1, 32'h10, 3'd3, 0, 0, 0, 0,                   1, 32'h0,        1));
    vecs.push_back(mkVec(0, 32'h0, 3'd0, 1, 32'h16, 32'hFFFF8001, 3'd1, 0, 32'h0,        0));
    vecs.push_back(mkVec(1, 32'h16, 3'd1, 0, 0, 0, 0,                   1, 32'hFFFF8001, 0));
    vecs.push_back(mkVec(1, 32'h16, 3'd5, 0, 0, 0, 0,                   1, 32'h00008001, 0));
    vecs.push_back(mkVec(0, 32'h0, 3'd0, 1, 32'h17, 32'h0000017F, 3'd0, 0, 32'h00008001, 0));
    vecs.push_back(mkVec(1, 32'h16, 3'd1, 0, 0, 0, 0,                   1, 32'h00007F01, 0));
    vecs.push_back(mkVec(0, 32'h0, 3'd0, 1, 32'h10, 32'h0, 3'd3,        0, 32'h00007F01, 1));
    vecs.push_back(mkVec(1, 32'h10, 3'd2, 0, 0, 0, 0,                   1, 32'h12345678, 0));
    vecs.push_back(mkVec(1, 32'h11, 3'd1, 1, 32'h12, 32'h1, 3'd2,       1, 32'h0,        1));
    vecs.push_back(mkVec(0, 32'h0, 3'd0, 0, 0, 0, 0,                    0, 32'h0,        0));

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(1, vecs[i]);
      tick();
      checkOutput($sformatf("vec%0d valid", i), 32'(bus1.mem_rd_valid_o), 32'(vecs[i].ev));
      checkOutput($sformatf("vec%0d data", i),  bus1.mem_rd_data_o,       vecs[i].ed);
      checkOutput($sformatf("vec%0d err", i),   32'(bus1.mem_err_o),      32'(vecs[i].ee));
      checkOutput($sformatf("vec%0d busy", i),  32'(bus1.mem_busy_o),     32'h0);
    end
    expLast = vecs[vecs.size()-1].ed;

    // Randomized run on the latency-1 instance against the word-level model
    for (int w = 0; w < 16; w++) begin
      modelMem[w] = $urandom;
      v = mkVec(0, 0, 0, 1, ($urandom & 32'hFFFFC000) | 32'(w << 2), modelMem[w], 3'd2, 0, 0, 0);
      applyStimulus(1, v);
      tick();
      checkOutput("fill err", 32'(bus1.mem_err_o), 32'h0);
    end
    for (int c = 0; c < 400; c++) begin
      int          rw, ww;
      logic [1:0]  ro, wo;
      logic        expValid, expErr;
      logic [31:0] expData;
      rw = $urandom_range(0, 15);
      ww = $urandom_range(0, 15);
      ro = 2'($urandom_range(0, 3));
      wo = 2'($urandom_range(0, 3));
      v.rd = 1'($urandom_range(0, 1));
      v.rf = 3'($urandom_range(0, 7));
      v.ra = ($urandom & 32'hFFFFC000) | 32'(rw << 2) | 32'(ro);
      v.wr = 1'($urandom_range(0, 1));
      v.wf = 3'($urandom_range(0, 7));
      v.wa = ($urandom & 32'hFFFFC000) | 32'(ww << 2) | 32'(wo);
      v.wd = $urandom;
      expValid = v.rd;
      if (v.rd) begin
        expData = badLoad(v.rf, ro) ? 32'h0 : modelLoad(modelMem[rw], ro, v.rf);
        expLast = expData;
      end else begin
        expData = expLast;
      end
      expErr = (v.rd && badLoad(v.rf, ro)) || (v.wr && badStore(v.wf, wo));
      if (v.wr && !badStore(v.wf, wo)) begin
        modelMem[ww] = modelStore(modelMem[ww], v.wd, wo, v.wf);
      end
      applyStimulus(1, v);
      tick();
      checkOutput($sformatf("rnd%0d valid", c), 32'(bus1.mem_rd_valid_o), 32'(expValid));
      checkOutput($sformatf("rnd%0d data", c),  bus1.mem_rd_data_o,       expData);
      checkOutput($sformatf("rnd%0d err", c),   32'(bus1.mem_err_o),      32'(expErr));
      checkOutput($sformatf("rnd%0d busy", c),  32'(bus1.mem_busy_o),     32'h0);
    end
    applyStimulus(1, idleVec());

    // Latency-3: preload two words
    applyStimulus(3, mkVec(0, 0, 0, 1, 32'h20, 32'hCAFEF00D, 3'd2, 0, 0, 0));
    tick();
    applyStimulus(3, mkVec(0, 0, 0, 1, 32'h24, 32'h11112222, 3'd2, 0, 0, 0));
    tick();
    applyStimulus(3, idleVec());
    tick();

    // Latency-3 timing, dropped request in WAIT, held request, store during WAIT
    applyStimulus(3, mkVec(1, 32'h20, 3'd2, 0, 0, 0, 0, 0, 0, 0));
    tick();
    check3("l3 c1", 0, 1, 32'h0, 0);
    applyStimulus(3, mkVec(1, 32'h24, 3'd2, 0, 0, 0, 0, 0, 0, 0));
    tick();
    check3("l3 c2", 0, 1, 32'h0, 0);
    applyStimulus(3, idleVec());
    tick();
    check3("l3 c3", 1, 0, 32'hCAFEF00D, 0);
    applyStimulus(3, mkVec(1, 32'h24, 3'd2, 0, 0, 0, 0, 0, 0, 0));
    tick();
    check3("l3 c4", 0, 1, 32'hCAFEF00D, 0);
    applyStimulus(3, mkVec(0, 0, 0, 1, 32'h24, 32'h99999999, 3'd2, 0, 0, 0));
    tick();
    check3("l3 c5", 0, 1, 32'hCAFEF00D, 0);
    applyStimulus(3, idleVec());
    tick();
    check3("l3 c6", 1, 0, 32'h11112222, 0);
    tick();
    check3("l3 c7", 0, 0, 32'h11112222, 0);

    // Latency-3: the store made during WAIT is visible to a later load
    applyStimulus(3, mkVec(1, 32'h24, 3'd2, 0, 0, 0, 0, 0, 0, 0));
    tick();
    applyStimulus(3, idleVec());
    tick();
    tick();
    check3("l3 late", 1, 0, 32'h99999999, 0);

    // Latency-3: misaligned word load reports error with valid
    applyStimulus(3, mkVec(1, 32'h22, 3'd2, 0, 0, 0, 0, 0, 0, 0));
    tick();
    applyStimulus(3, idleVec());
    check3("l3 err c1", 0, 1, 32'h99999999, 0);
    tick();
    tick();
    check3("l3 err c3", 1, 0, 32'h0, 1);
    tick();

    // Latency-3: reset in the middle of a read abandons it
    applyStimulus(3, mkVec(1, 32'h24, 3'd2, 0, 0, 0, 0, 0, 0, 0));
    tick();
    applyStimulus(3, idleVec());
    check3("l3 pre-rst", 0, 1, 32'h0, 0);
    rst3 = 1'b1;
    #1;
    check3("l3 rst", 0, 0, 32'h0, 0);
    #1;
    rst3 = 1'b0;
    for (int k = 2; k <= 6; k++) begin
      tick();
      check3($sformatf("l3 post-rst c%0d", k), 0, 0, 32'h0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/dmem_resp.md
Name: dmem_resp

Overview:
- Data-memory responder. It is the far end of the decode stage's load request (`mem_rd_req` / `mem_rd_addr`) and of the store path (base + offset resolved upstream).
- Holds the data RAM and serves loads with configurable latency, sign/zero-extending per load func3.
- Performs byte/half/word stores using byte enables.
- Flags misaligned or illegal accesses.

Parameters:
- ADDR_W, 12, word-index width; RAM depth = 2**ADDR_W 32-bit words.
- RD_LATENCY, 1, cycles from read accept to `mem_rd_valid_o`; legal range 1..4.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- mem_rd_req_i  in  1  load request.
- mem_rd_addr_i  in  32  load byte address.
- mem_rd_func3_i  in  3  load type: LB 000, LH 001, LW 010, LBU 100, LHU 101.
- mem_rd_data_o  out  32  extended load result.
- mem_rd_valid_o  out  1  one-cycle pulse when `mem_rd_data_o` is valid.
- mem_busy_o  out  1  read in flight; new read requests are ignored while high.
- mem_wr_req_i  in  1  store request.
- mem_wr_addr_i  in  32  store byte address.
- mem_wr_data_i  in  32  store data, value in the low bits.
- mem_wr_func3_i  in  3  store type: SB 000, SH 001, SW 010.
- mem_err_o  out  1  misaligned/illegal access pulse.

Behaviour:
- Reset (async, immediate):
  - `mem_rd_data_o`=0, `mem_rd_valid_o`=0, `mem_busy_o`=0, `mem_err_o`=0.
  - FSM to IDLE, latency counter 0, pending-error flag 0.
  - RAM contents are not reset.
- Addressing: word index = addr[ADDR_W+1:2]. Upper address bits are ignored, so addresses alias and wrap.
- Read FSM states: IDLE, WAIT, RESP.
  - IDLE or RESP, with `mem_rd_req_i`=1: accept the request.
    - Capture the RAM word, addr[1:0], func3 and the alignment check into a hold register at the accept edge.
    - Go to RESP if RD_LATENCY=1; otherwise go to WAIT with counter = RD_LATENCY-2.
  - WAIT: `mem_busy_o`=1. Counter decrements each cycle; at 0, go to RESP.
  - RESP: `mem_rd_valid_o`=1 for exactly one cycle, `mem_rd_data_o` is updated, `mem_busy_o`=0.
    - A request in this cycle is accepted (back-to-back), giving throughput of one read per RD_LATENCY cycles.
    - With no request, return to IDLE.
  - Requests arriving in WAIT are dropped. The requester must hold the request until `mem_busy_o` falls.
- Load extraction:
  - Byte/half lane is selected by the captured addr[1:0].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
  - `mem_rd_data_o` holds its last value between valid pulses.
- Alignment:
  - LH/LHU/SH require addr[0]=0.
  - LW/SW require addr[1:0]=00.
  - Load func3 011/110/111 and store func3 011..111 are illegal.
- Read error: no data selection; at RESP, `mem_rd_data_o`=0 and `mem_err_o`=1 in the same cycle as valid.
- Store:
  - Single cycle, independent of the read FSM and of `mem_busy_o`.
  - Byte enables: SB = 1<<addr[1:0]; SH = 0011 or 1100; SW = 1111.
  - Data is replicated to lanes (SB: byte x4, SH: half x2).
  - The RAM is written at the edge where `mem_wr_req_i`=1.
  - Misaligned or illegal store: no write; `mem_err_o` pulses the next cycle.
- Simultaneous read accept and store to the same word: read-before-write; the load returns old data. Stores to the word during WAIT do not affect the captured read.
- Read error and store error in the same cycle: a single `mem_err_o` pulse (OR).
- Reset during WAIT/RESP: the transaction is abandoned and no valid is issued after reset release.

Decomposition:
- Reuse the shared defines file for the func3 constants (INST_LB..INST_LHU, INST_SB/SH/SW).
- Add FSM state encodings (IDLE, WAIT, RESP) there as `DMEM_*` constants.
- One natural sub-module: `dmem_lane_align`, combinational.
  - Store path: byte-enable generation and lane replication.
  - Load path: lane select with sign/zero extension.
  - Also produces the alignment/illegal check.
- RAM stays inline as a reg array with per-byte writes.

Test Plan:
- RD_LATENCY=1: SW 0x10 data 0xDEADBEEF; next cycle LW 0x10 at t -> valid at t+1, data 0xDEADBEEF, busy never high.
- Loads from 0x10 after the SW above:
  - LB 0x13 -> 0xFFFFFFDE
  - LBU 0x13 -> 0x000000DE
  - LH 0x12 -> 0xFFFFDEAD
  - LHU 0x10 -> 0x0000BEEF
- SB 0x11 data 0x000000AA, then LW 0x10 -> 0xDEADAAEF. Same-cycle SW 0x10 data 0x0 plus LW 0x10 -> returns 0xDEADAAEF, and a later LW returns 0.
- RD_LATENCY=3:
  - LW accepted at cycle 0 -> busy=1 in cycles 1-2, valid at cycle 3.
  - A second request at cycle 1 is dropped.
  - A request held through cycle 3 is accepted and gives valid at cycle 6.
- Errors:
  - LW 0x12 -> at the latency point, valid=1, err=1, data=0.
  - SH 0x11 -> err pulse next cycle; LW 0x10 is unchanged.
  - Load func3 011 -> err with valid.
- RD_LATENCY=3: `rst` pulsed at cycle 1 of a read -> all outputs 0 immediately, and no valid in cycles 2-6.
